// File: rtl/instr_encoder.sv
// instr_encoder: RV32I instruction encoder with an output FIFO.
//
// Requests (format, ALU op / branch condition, register indices, full
// immediate) are encoded combinationally and pushed into a DEPTH-entry FIFO
// on the same cycle they are accepted. Illegal requests are accepted and
// dropped. Each one raises err_o for one cycle and bumps a saturating 8-bit
// counter.
//
// Ports:
//   clk          in   clock, all state on the rising edge
//   rst          in   synchronous active-high reset
//   in_valid_i   in   encode request valid
//   in_ready_o   out  request can be accepted (FIFO not full)
//   fmt_i        in   0=R 1=I 2=LUI 3=AUIPC 4=B, 5-7 illegal
//   alu_op_i     in   ALU operation for R/I formats
//   br_funct3_i  in   branch condition for B format
//   rs1_i/rs2_i/rd_i in register indices
//   imm_i        in   full 32-bit immediate as a decoder would produce it
//   instr_o      out  encoded word at the FIFO head (0 after reset)
//   out_valid_o  out  FIFO non-empty
//   out_ready_i  in   consumer takes instr_o
//   err_o        out  one-cycle pulse after an illegal request is accepted
//   err_cnt_o    out  saturating count of illegal requests

package instr_encoder_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_opcode_e;
endpackage

module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [2:0]  fmt_i,
    input  alu_opcode_e alu_op_i,
    input  logic [2:0]  br_funct3_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] imm_i,
    output logic [31:0] instr_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        err_o,
    output logic [7:0]  err_cnt_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // ------------------------------------------------------------------
    // Combinational encoder
    // ------------------------------------------------------------------
    logic [2:0]  alu_f3;
    logic [6:0]  alu_f7;
    logic        op_bad;
    logic        op_shift;
    logic [31:0] enc_word;
    logic        illegal;

    always_comb begin
        alu_f3   = 3'b000;
        alu_f7   = 7'b0000000;
        op_bad   = 1'b0;
        op_shift = 1'b0;
        case (alu_op_i)
            ALU_ADD:  alu_f3 = 3'b000;
            ALU_SUB: begin
                alu_f3 = 3'b000;
                alu_f7 = 7'b0100000;
            end
            ALU_SLL: begin
                alu_f3   = 3'b001;
                op_shift = 1'b1;
            end
            ALU_SLT:  alu_f3 = 3'b010;
            ALU_SLTU: alu_f3 = 3'b011;
            ALU_XOR:  alu_f3 = 3'b100;
            ALU_SRL: begin
                alu_f3   = 3'b101;
                op_shift = 1'b1;
            end
            ALU_SRA: begin
                alu_f3   = 3'b101;
                alu_f7   = 7'b0100000;
                op_shift = 1'b1;
            end
            ALU_OR:   alu_f3 = 3'b110;
            ALU_AND:  alu_f3 = 3'b111;
            default:  op_bad = 1'b1;
        endcase
    end

    always_comb begin
        enc_word = 32'd0;
        illegal  = 1'b0;
        case (fmt_i)
            3'd0: begin
                enc_word = {alu_f7, rs2_i, rs1_i, alu_f3, rd_i, OPC_OP};
                illegal  = op_bad;
            end
            3'd1: begin
                if (op_shift) begin
                    // Shift amount lives in the rs2 slot; only SRA sets funct7.
                    enc_word = {alu_f7, imm_i[4:0], rs1_i, alu_f3, rd_i, OPC_OP_IMM};
                    illegal  = op_bad || (imm_i[31:5] != 27'd0);
                end else begin
                    enc_word = {imm_i[11:0], rs1_i, alu_f3, rd_i, OPC_OP_IMM};
                    // Value must be a sign-extended 12-bit quantity.
                    illegal  = op_bad || (alu_op_i == ALU_SUB) ||
                               !((imm_i[31:11] == 21'd0) || (imm_i[31:11] == {21{1'b1}}));
                end
            end
            3'd2: begin
                enc_word = {imm_i[31:12], rd_i, OPC_LUI};
                illegal  = (imm_i[11:0] != 12'd0);
            end
            3'd3: begin
                enc_word = {imm_i[31:12], rd_i, OPC_AUIPC};
                illegal  = (imm_i[11:0] != 12'd0);
            end
            3'd4: begin
                enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, br_funct3_i,
                            imm_i[4:1], imm_i[11], OPC_BRANCH};
                // Even offset, sign-extended 13-bit range, valid condition.
                illegal  = imm_i[0] ||
                           !((imm_i[31:12] == 20'd0) || (imm_i[31:12] == {20{1'b1}})) ||
                           (br_funct3_i == 3'b010) || (br_funct3_i == 3'b011);
            end
            default: illegal = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [31:0]      head_reg;
    logic             err_reg;
    logic [7:0]       err_cnt_reg;

    logic             accept;
    logic             push;
    logic             pop;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count_next;
    logic [31:0]      head_next;

    assign in_ready_o  = (count_reg != FULL_CNT);
    assign out_valid_o = (count_reg != '0);
    assign accept      = in_valid_i && in_ready_o;
    assign push        = accept && !illegal;
    assign pop         = out_valid_o && out_ready_i;

    always_comb begin
        rd_ptr_next = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
        count_next  = count_reg + CNT_W'(push) - CNT_W'(pop);
        // The head after this edge is either an entry already stored or,
        // when the FIFO is otherwise empty, the word being pushed right now.
        if (push && (wr_ptr_reg == rd_ptr_next)) begin
            head_next = enc_word;
        end else begin
            head_next = mem[rd_ptr_next];
        end
    end

    // Storage array: no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= enc_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            head_reg    <= 32'd0;
            err_reg     <= 1'b0;
            err_cnt_reg <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            // Head register holds its last value once the FIFO drains.
            if (count_next != '0) begin
                head_reg <= head_next;
            end
            err_reg <= accept && illegal;
            if (accept && illegal && (err_cnt_reg != 8'hFF)) begin
                err_cnt_reg <= err_cnt_reg + 8'd1;
            end
        end
    end

    assign instr_o   = head_reg;
    assign err_o     = err_reg;
    assign err_cnt_o = err_cnt_reg;

endmodule
